cache_fill_arbiter: RTL and testbench
=====================================

Name: cache_fill_arbiter

Overview:
- Multi-cycle controller that shares the single pipelined main memory between I-cache and D-cache miss fills.
- Sits between both caches and main memory. Fetch stalls on an I-cache miss, and the MEM stage stalls on a D-cache miss, until this block pulses the matching fill_done.
- Each fill streams one cache block from memory: issues WORDS_PER_BLOCK word reads back-to-back and routes the returning words to the cache that owns the fill.

Parameters:
- MEM_LATENCY, 4, cycles from mem_en/mem_addr issue to mem_data_valid/mem_data_in return (memory is fully pipelined).
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; must be a power of 2.
- IDX_W, 3, log2(WORDS_PER_BLOCK).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- icache_miss  input  1  I-cache needs a fill; held high until satisfied.
- icache_miss_addr  input  16  byte address of the I-cache miss.
- dcache_miss  input  1  D-cache needs a fill; held high until satisfied.
- dcache_miss_addr  input  16  byte address of the D-cache miss.
- mem_data_valid  input  1  returning read word is valid this cycle.
- mem_data_in  input  16  returning read word.
- mem_en  output  1  issue a read this cycle.
- mem_addr  output  16  read address issued.
- fill_data  output  16  word to write into the owning cache (equals mem_data_in).
- fill_word_idx  output  IDX_W  word slot within the block for fill_data.
- fill_tag_addr  output  16  block base address of the current fill.
- icache_fill_wen  output  1  write fill_data into the I-cache.
- dcache_fill_wen  output  1  write fill_data into the D-cache.
- icache_fill_done  output  1  one-cycle pulse: I-cache block complete.
- dcache_fill_done  output  1  one-cycle pulse: D-cache block complete.
- busy  output  1  high in every state except IDLE.

Behaviour:
- States: IDLE, FILL, DONE. Registers:
  - owner: 0 = I, 1 = D.
  - last_grant.
  - base address.
  - issue_cnt and recv_cnt, each IDX_W+1 bits.
- Reset, asynchronous, effective immediately:
  - state = IDLE, counters = 0, owner = 0, last_grant = 0, base = 0.
  - All outputs 0.
  - In-flight memory returns are ignored after reset.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only one request pending: grant it.
  - Both pending: grant D, unless last_grant = D, in which case grant I. This alternation prevents fetch starvation.
  - On grant, at the clock edge:
    - base = miss_addr with low log2(2*WORDS_PER_BLOCK) bits cleared (bits [3:0] for 8 words).
    - Latch owner and last_grant; clear counters; go to FILL.
- FILL, issue side:
  - While issue_cnt < WORDS_PER_BLOCK: mem_en = 1, mem_addr = base + 2*issue_cnt, and issue_cnt increments each cycle.
  - Issue is unconditional; the memory never backpressures.
- FILL, receive side:
  - When mem_data_valid = 1: owner's fill_wen = 1, fill_word_idx = recv_cnt[IDX_W-1:0], fill_data = mem_data_in; recv_cnt increments.
  - mem_data_valid while in IDLE or DONE is ignored (no wen).
  - Receive occurs in the same cycles as issue once MEM_LATENCY has elapsed.
- FILL exit: when the last word is received (recv_cnt = WORDS_PER_BLOCK-1 and mem_data_valid), go to DONE.
- DONE:
  - Owner's fill_done = 1 for exactly one cycle.
  - Next state is IDLE; a new grant is possible the following cycle.
- Latency, with the grant edge at the end of cycle 0:
  - First issue in cycle 1, last issue in cycle WORDS_PER_BLOCK.
  - Last wen in cycle WORDS_PER_BLOCK + MEM_LATENCY.
  - fill_done in cycle WORDS_PER_BLOCK + MEM_LATENCY + 1; cycle 13 with the defaults.
- A fill is never preempted or aborted. If the requester drops its miss mid-fill (e.g. fetch redirected on a misprediction), the block still completes and fill_done still pulses.
- The requester drops its miss by the cycle after fill_done, since the line became valid on the final wen edge. The arbiter does not re-serve that miss.
- fill_tag_addr = base during FILL and DONE; 0 in IDLE.
- Address arithmetic is 16-bit. A block's addresses never wrap, because base is block-aligned.

Test Plan:
- Reset, then icache_miss = 1 with addr 0x0036: base 0x0030. mem_addr 0x0030, 0x0032 … 0x003E in cycles 1–8. icache_fill_wen in cycles 5–12 with idx 0–7. icache_fill_done pulses in cycle 13 only. dcache_* stay 0 throughout.
- Both misses raised in the same cycle (I 0x1000, D 0x2004): D fill first (base 0x2000), then I fill (base 0x1000), with one IDLE cycle between. I is granted next even if D re-misses at 0x4000 in that IDLE cycle.
- dcache_miss continuously re-raised at new addresses while icache_miss is held: grants alternate D, I, D, I. No two consecutive D grants while I is pending.
- icache_miss dropped at cycle 3 of a fill: all 8 icache_fill_wen still occur and icache_fill_done still pulses.
- rst asserted mid-fill at cycle 6: outputs go to 0 asynchronously, state IDLE. Returning mem_data_valid in cycles 7–10 produces no wen. A miss after reset release fills normally from word 0.
- Spurious mem_data_valid while in IDLE: no fill_wen, no state change, busy stays 0.

Source files
------------

// File: rtl/cache_fill_arbiter_if.sv
// Bus bundle between the fill arbiter, the two caches and main memory.
// Handshake: mem_en/mem_addr is a one-cycle read request with no ready (memory
// always accepts); mem_data_valid qualifies mem_data_in for exactly that cycle;
// *_fill_wen qualifies fill_data/fill_word_idx; *_fill_done is a single-cycle pulse.
interface cache_fill_arbiter_if #(
   parameter int IDX_W = 3
);
   logic              icache_miss;
   logic [15:0]       icache_miss_addr;
   logic              dcache_miss;
   logic [15:0]       dcache_miss_addr;
   logic              mem_data_valid;
   logic [15:0]       mem_data_in;
   logic              mem_en;
   logic [15:0]       mem_addr;
   logic [15:0]       fill_data;
   logic [IDX_W-1:0]  fill_word_idx;
   logic [15:0]       fill_tag_addr;
   logic              icache_fill_wen;
   logic              dcache_fill_wen;
   logic              icache_fill_done;
   logic              dcache_fill_done;
   logic              busy;

   // Arbiter side.
   modport master (
      input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
             mem_data_valid, mem_data_in,
      output mem_en, mem_addr, fill_data, fill_word_idx, fill_tag_addr,
             icache_fill_wen, dcache_fill_wen, icache_fill_done,
             dcache_fill_done, busy
   );

   // Cache / memory side.
   modport slave (
      output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
             mem_data_valid, mem_data_in,
      input  mem_en, mem_addr, fill_data, fill_word_idx, fill_tag_addr,
             icache_fill_wen, dcache_fill_wen, icache_fill_done,
             dcache_fill_done, busy
   );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Shares one pipelined main memory between I-cache and D-cache block fills.
// A granted fill issues WORDS_PER_BLOCK reads back-to-back, routes the returning
// words to the owning cache and pulses that cache's fill_done once the block is in.
module cache_fill_arbiter #(
   parameter int MEM_LATENCY     = 4,
   parameter int WORDS_PER_BLOCK = 8,
   parameter int IDX_W           = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   cache_fill_arbiter_if.master bus,
   output logic [1:0]           state_dbg
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FILL = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int CNT_W   = IDX_W + 1;
   localparam int BLANK_W = $clog2(MEM_LATENCY + 1);

   localparam logic [CNT_W-1:0]   WORDS      = CNT_W'(WORDS_PER_BLOCK);
   localparam logic [CNT_W-1:0]   LAST_WORD  = CNT_W'(WORDS_PER_BLOCK - 1);
   localparam logic [15:0]        ALIGN_MASK = ~(16'(2 * WORDS_PER_BLOCK) - 16'd1);
   localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'(MEM_LATENCY);

   logic [1:0]         state;
   logic               owner;        // 0 = I-cache, 1 = D-cache
   logic               last_grant;   // owner of the previous grant
   logic [15:0]        base;
   logic [CNT_W-1:0]   issue_cnt;
   logic [CNT_W-1:0]   recv_cnt;
   // Reads issued before a reset may still return afterwards; returns are
   // ignored until every such read has drained out of the memory pipeline.
   logic [BLANK_W-1:0] blank_cnt;

   logic               grant_vld;
   logic               grant_d;
   logic [15:0]        grant_base;
   logic               issue;
   logic               recv;

   // Request arbitration: D wins a tie unless D had the previous grant.
   always_comb begin
      grant_vld  = bus.icache_miss | bus.dcache_miss;
      grant_d    = bus.dcache_miss & (~bus.icache_miss | ~last_grant);
      grant_base = (grant_d ? bus.dcache_miss_addr : bus.icache_miss_addr) & ALIGN_MASK;
   end

   // Issue while words remain; accept returns only inside a fill.
   always_comb begin
      issue = (state == S_FILL) && (issue_cnt < WORDS);
      recv  = (state == S_FILL) && bus.mem_data_valid && (blank_cnt == '0);
   end

   // FSM, fill bookkeeping and post-reset return blanking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b0;
         base       <= '0;
         issue_cnt  <= '0;
         recv_cnt   <= '0;
         blank_cnt  <= BLANK_INIT;
      end else begin
         if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - BLANK_W'(1);
         end
         case (state)
            S_IDLE: begin
               if (grant_vld) begin
                  owner      <= grant_d;
                  last_grant <= grant_d;
                  base       <= grant_base;
                  issue_cnt  <= '0;
                  recv_cnt   <= '0;
                  state      <= S_FILL;
               end
            end
            S_FILL: begin
               if (issue) begin
                  issue_cnt <= issue_cnt + CNT_W'(1);
               end
               if (recv) begin
                  recv_cnt <= recv_cnt + CNT_W'(1);
                  if (recv_cnt == LAST_WORD) begin
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs decoded from state; everything reads 0 outside its qualifying window.
   always_comb begin
      bus.mem_en           = issue;
      bus.mem_addr         = issue ? base + {{(15 - CNT_W){1'b0}}, issue_cnt, 1'b0} : 16'h0000;
      bus.fill_data        = recv ? bus.mem_data_in : 16'h0000;
      bus.fill_word_idx    = recv ? recv_cnt[IDX_W-1:0] : '0;
      bus.fill_tag_addr    = (state != S_IDLE) ? base : 16'h0000;
      bus.icache_fill_wen  = recv & ~owner;
      bus.dcache_fill_wen  = recv & owner;
      bus.icache_fill_done = (state == S_DONE) & ~owner;
      bus.dcache_fill_done = (state == S_DONE) & owner;
      bus.busy             = (state != S_IDLE);
      state_dbg            = state;
   end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: pipelined memory model, cycle-offset reference
// model of a fill, grant scoreboard, table vectors and directed corner sequences.
module tb_cache_fill_arbiter;
   localparam int LAT    = 4;
   localparam int W      = 8;
   localparam int IDX_W  = 3;
   localparam int P_DONE = W + LAT + 1;
   localparam logic [15:0] ALIGN = ~(16'(2 * W) - 16'd1);

   typedef struct packed {
      logic             mem_en;
      logic [15:0]      mem_addr;
      logic [15:0]      fill_data;
      logic [IDX_W-1:0] idx;
      logic [15:0]      tag;
      logic             iwen;
      logic             dwen;
      logic             idone;
      logic             ddone;
      logic             busy;
   } out_t;

   typedef struct {
      logic        is_d;
      logic [15:0] addr;
      logic [15:0] exp_base;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0] state_dbg;
   logic        i_miss = 1'b0, d_miss = 1'b0;
   logic [15:0] i_addr = '0, d_addr = '0;
   logic        spur_v = 1'b0;
   logic [15:0] spur_d = '0;

   cache_fill_arbiter_if #(.IDX_W(IDX_W)) bus ();

   cache_fill_arbiter #(
      .MEM_LATENCY(LAT), .WORDS_PER_BLOCK(W), .IDX_W(IDX_W)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
   );

   function automatic logic [15:0] memf(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   // ---------------- memory model (never reset) ----------------
   logic [LAT-1:0]       pv = '0;
   logic [LAT-1:0][15:0] pa = '0;
   always @(posedge clk) begin
      pv <= {pv[LAT-2:0], bus.mem_en};
      pa <= {pa[LAT-2:0], bus.mem_addr};
   end
   assign bus.icache_miss      = i_miss;
   assign bus.icache_miss_addr = i_addr;
   assign bus.dcache_miss      = d_miss;
   assign bus.dcache_miss_addr = d_addr;
   assign bus.mem_data_valid   = pv[LAT-1] | spur_v;
   assign bus.mem_data_in      = spur_v ? spur_d : memf(pa[LAT-1]);

   // ---------------- reference model / scoreboard ----------------
   int          n_vec = 0, n_bad = 0;
   int          m_phase = 0;       // cycles since grant edge, 0 = idle
   logic        m_owner = 1'b0, m_last = 1'b0;
   logic [15:0] m_base = '0;
   logic [16:0] exp_q[$];          // {owner, base} per expected fill
   logic        got_owner[$];
   logic        seen_i, seen_d;
   logic [15:0] last_tag;
   int          n_iwen = 0, n_dwen = 0;

   function automatic out_t model_out();
      out_t e;
      int   k;
      e = '0;
      if (m_phase != 0) begin
         e.busy = 1'b1;
         e.tag  = m_base;
         if (m_phase <= W) begin
            e.mem_en   = 1'b1;
            e.mem_addr = m_base + 16'(2 * (m_phase - 1));
         end
         if (m_phase > LAT && m_phase <= W + LAT) begin
            k           = m_phase - LAT - 1;
            e.idx       = IDX_W'(k);
            e.fill_data = memf(m_base + 16'(2 * k));
            if (m_owner) e.dwen = 1'b1; else e.iwen = 1'b1;
         end
         if (m_phase == P_DONE) begin
            if (m_owner) e.ddone = 1'b1; else e.idone = 1'b1;
         end
      end
      return e;
   endfunction

   function automatic out_t sample_dut();
      out_t a;
      a.mem_en    = bus.mem_en;
      a.mem_addr  = bus.mem_addr;
      a.fill_data = bus.fill_data;
      a.idx       = bus.fill_word_idx;
      a.tag       = bus.fill_tag_addr;
      a.iwen      = bus.icache_fill_wen;
      a.dwen      = bus.dcache_fill_wen;
      a.idone     = bus.icache_fill_done;
      a.ddone     = bus.dcache_fill_done;
      a.busy      = bus.busy;
      return a;
   endfunction

   task automatic model_edge();
      logic gd;
      if (m_phase == 0) begin
         if (i_miss || d_miss) begin
            gd      = d_miss && !(i_miss && m_last);
            m_owner = gd;
            m_last  = gd;
            m_base  = (gd ? d_addr : i_addr) & ALIGN;
            m_phase = 1;
            exp_q.push_back({gd, m_base});
         end
      end else if (m_phase == P_DONE) begin
         m_phase = 0;
      end else begin
         m_phase++;
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", name, got, exp);
      end
   endtask

   // One clock: compare at negedge, advance model at posedge, return at posedge+1.
   task automatic step();
      out_t        e, a;
      logic [16:0] eg;
      @(negedge clk);
      e = model_out();
      a = sample_dut();
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL outputs t=%0t phase=%0d got=%h exp=%h", $time, m_phase, a, e);
      end
      seen_i  = a.idone;
      seen_d  = a.ddone;
      n_iwen += int'(a.iwen);
      n_dwen += int'(a.dwen);
      if (a.idone || a.ddone) begin
         got_owner.push_back(a.ddone);
         last_tag = a.tag;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL grant_sb: got=%h exp=none", {a.ddone, a.tag});
         end else begin
            eg = exp_q.pop_front();
            if ({a.ddone, a.tag} !== eg) begin
               n_bad++;
               $display("FAIL grant_sb: got=%h exp=%h", {a.ddone, a.tag}, eg);
            end
         end
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Step until n fill_done pulses; requesters drop on done, optionally re-raise.
   task automatic run(input int n, input bit re_i, input bit re_d);
      int dones = 0;
      for (int c = 0; c < n * 20 + 20 && dones < n; c++) begin
         step();
         if (seen_i) begin
            dones++;
            i_miss = re_i;
            i_addr = 16'($urandom);
         end
         if (seen_d) begin
            dones++;
            d_miss = re_d;
            d_addr = 16'($urandom);
         end
      end
      n_vec++;
      if (dones < n) begin
         n_bad++;
         $display("FAIL run_timeout: got=%0d dones exp=%0d", dones, n);
      end
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      i_miss = 1'b0;
      d_miss = 1'b0;
      m_phase = 0;
      m_last  = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("reset_outputs", 32'(sample_dut()), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   vec_t vecs[6];
   logic exp_alt[6];

   initial begin
      vecs[0] = '{1'b0, 16'h0036, 16'h0030};
      vecs[1] = '{1'b1, 16'h2004, 16'h2000};
      vecs[2] = '{1'b0, 16'hFFFE, 16'hFFF0};
      vecs[3] = '{1'b1, 16'h000F, 16'h0000};
      vecs[4] = '{1'b1, 16'h1234, 16'h1230};
      vecs[5] = '{1'b0, 16'h8009, 16'h8000};
      exp_alt = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      // Reset state.
      @(posedge clk);
      #1;
      do_reset();

      // Table: single-requester fills.
      foreach (vecs[v]) begin
         n_iwen = 0; n_dwen = 0; got_owner.delete();
         if (vecs[v].is_d) begin d_miss = 1'b1; d_addr = vecs[v].addr; end
         else              begin i_miss = 1'b1; i_addr = vecs[v].addr; end
         run(1, 1'b0, 1'b0);
         check("vec_owner", 32'(got_owner.size() > 0 ? got_owner[0] : 1'bx), 32'(vecs[v].is_d));
         check("vec_base", 32'(last_tag), 32'(vecs[v].exp_base));
         check("vec_wen_count", {16'(n_iwen), 16'(n_dwen)},
               vecs[v].is_d ? {16'd0, 16'd8} : {16'd8, 16'd0});
      end

      // Simultaneous misses: D first, then I even though D re-misses.
      do_reset();
      got_owner.delete();
      i_miss = 1'b1; i_addr = 16'h1000;
      d_miss = 1'b1; d_addr = 16'h2004;
      run(3, 1'b0, 1'b1);
      d_miss = 1'b0;
      check("tie_order_len", 32'(got_owner.size()), 32'd3);
      for (int k = 0; k < 3 && k < got_owner.size(); k++)
         check("tie_order", 32'(got_owner[k]), 32'(exp_alt[k]));

      // Continuous contention: strict alternation.
      do_reset();
      got_owner.delete();
      i_miss = 1'b1; i_addr = 16'h0100;
      d_miss = 1'b1; d_addr = 16'h3000;
      run(6, 1'b1, 1'b1);
      i_miss = 1'b0; d_miss = 1'b0;
      check("alt_order_len", 32'(got_owner.size()), 32'd6);
      for (int k = 0; k < 6 && k < got_owner.size(); k++)
         check("alt_order", 32'(got_owner[k]), 32'(exp_alt[k]));

      // I-cache drops its miss mid-fill: block still completes.
      n_iwen = 0; n_dwen = 0;
      i_miss = 1'b1; i_addr = 16'h0500;
      repeat (3) step();
      i_miss = 1'b0;
      run(1, 1'b0, 1'b0);
      check("drop_wen_count", 32'(n_iwen), 32'd8);

      // Reset in cycle 6 of a fill; stale returns must not write.
      i_miss = 1'b1; i_addr = 16'h0700;
      repeat (6) step();
      #2 rst = 1'b1;
      #1 check("async_reset_outputs", 32'(sample_dut()), 32'd0);
      m_phase = 0; m_last = 1'b0; exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      n_iwen = 0;
      run(1, 1'b0, 1'b0);
      check("post_reset_wen_count", 32'(n_iwen), 32'd8);

      // Spurious returns while idle.
      for (int k = 0; k < 3; k++) begin
         spur_v = 1'b1;
         spur_d = 16'($urandom);
         step();
      end
      spur_v = 1'b0;
      check("spurious_busy", 32'(bus.busy), 32'd0);

      // Randomized traffic against the model.
      for (int c = 0; c < 500; c++) begin
         if (!i_miss && $urandom_range(0, 2) == 0) begin i_miss = 1'b1; i_addr = 16'($urandom); end
         else if (i_miss && $urandom_range(0, 15) == 0) i_miss = 1'b0;
         if (!d_miss && $urandom_range(0, 2) == 0) begin d_miss = 1'b1; d_addr = 16'($urandom); end
         else if (d_miss && $urandom_range(0, 15) == 0) d_miss = 1'b0;
         step();
         if (seen_i) i_miss = 1'b0;
         if (seen_d) d_miss = 1'b0;
      end
      i_miss = 1'b0; d_miss = 1'b0;
      for (int c = 0; c < 40 && m_phase != 0; c++) step();
      repeat (2) step();
      check("drain_pending_grants", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
